// File: rtl/logic_unit_pkg.sv
// Shared opcode definitions for the arbitrated bitwise logic unit.
// Opcode values line up with the numbering of the n-bit gate set.
package logic_unit_pkg;

  localparam int OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_NOT     = 3'd0,
    OP_AND     = 3'd1,
    OP_OR      = 3'd2,
    OP_NAND    = 3'd3,
    OP_NOR     = 3'd4,
    OP_XOR     = 3'd5,
    OP_XNOR    = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_e;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational WIDTH-bit gate bank with an opcode-selected result.
// Opcode 7 yields zero data and raises the illegal flag.
module logic_op_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [OPW-1:0]   i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_data,
  output logic             o_illegal
);

  logic [WIDTH-1:0] w_not;
  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_or;
  logic [WIDTH-1:0] w_nand;
  logic [WIDTH-1:0] w_nor;
  logic [WIDTH-1:0] w_xor;
  logic [WIDTH-1:0] w_xnor;

  assign w_not  = ~i_a;
  assign w_and  = i_a & i_b;
  assign w_or   = i_a | i_b;
  assign w_nand = ~(i_a & i_b);
  assign w_nor  = ~(i_a | i_b);
  assign w_xor  = i_a ^ i_b;
  assign w_xnor = ~(i_a ^ i_b);

  always_comb begin
    o_data    = '0;
    o_illegal = 1'b0;
    unique case (i_op)
      OP_NOT:  o_data = w_not;
      OP_AND:  o_data = w_and;
      OP_OR:   o_data = w_or;
      OP_NAND: o_data = w_nand;
      OP_NOR:  o_data = w_nor;
      OP_XOR:  o_data = w_xor;
      OP_XNOR: o_data = w_xnor;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic unit among NUM_REQ requesters,
// with a capture stage (S1) and a result stage (S2).
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 2,
  parameter int IDW     = 1,
  parameter int CNTW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [OPW*NUM_REQ-1:0]   req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic [IDW-1:0]           res_id,
  output logic                     res_zero,
  output logic                     res_err,
  output logic [CNTW-1:0]          ops_done
);

  localparam logic [IDW:0] NR = (IDW+1)'(NUM_REQ);

  logic [IDW-1:0]   r_ptr;
  logic             r_s1_v;
  logic [OPW-1:0]   r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [IDW-1:0]   r_s1_id;
  logic             r_s2_v;
  logic [WIDTH-1:0] r_res_data;
  logic [IDW-1:0]   r_res_id;
  logic             r_res_zero;
  logic             r_res_err;
  logic [CNTW-1:0]  r_ops_done;

  logic               w_s2_free;
  logic               w_s1_adv;
  logic               w_s1_free;
  logic               w_found;
  logic               w_acc;
  logic [IDW-1:0]     w_gnt;
  logic [IDW:0]       w_sum;
  logic [IDW:0]       w_pn;
  logic [IDW-1:0]     w_ptr_nxt;
  logic [2*NUM_REQ-1:0] w_rot;
  logic [OPW-1:0]     w_op;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [WIDTH-1:0]   w_data;
  logic               w_illegal;

  assign w_s2_free = !r_s2_v || res_ready;
  assign w_s1_adv  = r_s1_v && w_s2_free;
  assign w_s1_free = !r_s1_v || w_s1_adv;

  // Rotate so bit 0 is the pointer's requester, then take the first set bit.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_sum   = '0;
    w_rot   = {req_valid, req_valid} >> r_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_ptr} + (IDW+1)'(i);
        if (w_sum >= NR) w_sum = w_sum - NR;
        w_gnt   = w_sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    w_pn = {1'b0, w_gnt} + (IDW+1)'(1);
    if (w_pn >= NR) w_pn = '0;
    w_ptr_nxt = w_pn[IDW-1:0];
  end

  assign w_acc = w_found && w_s1_free && !rst;

  always_comb begin
    req_ready = '0;
    if (w_acc) req_ready[w_gnt] = 1'b1;
  end

  always_comb begin
    w_op = '0;
    w_a  = '0;
    w_b  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_gnt == IDW'(k)) begin
        w_op = req_op[k*OPW +: OPW];
        w_a  = req_a[k*WIDTH +: WIDTH];
        w_b  = req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  logic_op_unit #(
    .WIDTH(WIDTH)
  ) u_op (
    .i_op      (r_s1_op),
    .i_a       (r_s1_a),
    .i_b       (r_s1_b),
    .o_data    (w_data),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_s1_v     <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_id    <= '0;
      r_s2_v     <= 1'b0;
      r_res_data <= '0;
      r_res_id   <= '0;
      r_res_zero <= 1'b0;
      r_res_err  <= 1'b0;
      r_ops_done <= '0;
    end else begin
      if (w_acc) begin
        r_s1_v  <= 1'b1;
        r_s1_op <= w_op;
        r_s1_a  <= w_a;
        r_s1_b  <= w_b;
        r_s1_id <= w_gnt;
        r_ptr   <= w_ptr_nxt;
      end else if (w_s1_adv) begin
        r_s1_v <= 1'b0;
      end
      if (w_s1_adv) begin
        r_s2_v     <= 1'b1;
        r_res_data <= w_data;
        r_res_id   <= r_s1_id;
        r_res_zero <= (w_data == '0);
        r_res_err  <= w_illegal;
      end else if (res_ready) begin
        r_s2_v <= 1'b0;
      end
      if (r_s2_v && res_ready) r_ops_done <= r_ops_done + 1'b1;
    end
  end

  assign res_valid = r_s2_v;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign res_zero  = r_res_zero;
  assign res_err   = r_res_err;
  assign ops_done  = r_ops_done;

endmodule
